// File: rtl/stream_word_accum_pkg.sv
// rtl/stream_word_accum_pkg.sv - shared types and defaults for the stream word accumulator
// Mode encoding matches the 2-bit mode field driven by the EEPROM controller.
package stream_accum_pkg;

  typedef enum logic [1:0] {
    ACC_SUM  = 2'b00,
    ACC_XOR  = 2'b01,
    ACC_MAX  = 2'b10,
    ACC_HOLD = 2'b11
  } AccMode_t;

  // Same bit order as the controller's output bundle.
  typedef struct packed {
    logic word;
    logic b;
    logic data;
    logic valid;
  } BitPacket_t;

  localparam int DEF_WORD_W = 32;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_READ_W = 4;

endpackage

// File: rtl/stream_word_accum_if.sv
// rtl/stream_word_accum_if.sv - serial bit stream from the EEPROM controller
// The controller drives through master; the accumulator samples through slave.
interface stream_word_accum_if;

  logic IN_data;
  logic IN_valid;
  logic IN_word;

  modport master (output IN_data, output IN_valid, output IN_word);
  modport slave  (input  IN_data, input  IN_valid, input  IN_word);

endinterface

// File: rtl/stream_word_accum_lane.sv
// rtl/stream_word_accum_lane.sv - one accumulator lane with mode combine and sticky carry flag
// Clear has priority over enable so a clear on a commit cycle drops the word.
module accum_lane
  import stream_accum_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int WORD_W = DEF_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clear_i,
  input  AccMode_t          mode_i,
  input  logic [WORD_W-1:0] word_i,
  output logic [ACC_W-1:0]  acc_o,
  output logic              ovf_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] word_ext;
  logic [ACC_W:0]   sum_ext;

  assign word_ext = ACC_W'(word_i);
  assign sum_ext  = {1'b0, acc_q} + {1'b0, word_ext};

  always_comb begin
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (clear_i) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      case (mode_i)
        ACC_SUM: begin
          acc_d = sum_ext[ACC_W-1:0];
          ovf_d = ovf_q | sum_ext[ACC_W];
        end
        ACC_XOR:  acc_d = acc_q ^ word_ext;
        ACC_MAX:  acc_d = (word_ext > acc_q) ? word_ext : acc_q;
        default:  acc_d = acc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc_o = acc_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/stream_word_accum.sv
// rtl/stream_word_accum.sv - assembles serial bits into words and accumulates them across lanes
// Holds the shift register, round-robin pointer, word counter and registered readout slice.
module stream_word_accum
  import stream_accum_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int READ_W = DEF_READ_W,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int NSLICE = ACC_W / READ_W,
  localparam int SEL_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  stream_word_accum_if.slave        bit_if,
  input  AccMode_t                  IN_mode,
  input  logic                      IN_rr,
  input  logic [CH_W-1:0]           IN_ch,
  input  logic                      IN_clear,
  input  logic [CH_W-1:0]           IN_rdCh,
  input  logic [SEL_W-1:0]          IN_rdSel,
  output logic [READ_W-1:0]         OUT_rdata,
  output logic [WORD_W-1:0]         OUT_word,
  output logic                      OUT_wordValid,
  output logic [NUM_CH-1:0]         OUT_ovf,
  output logic [15:0]               OUT_wordCnt
);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              wv_q, wv_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [READ_W-1:0] rd_q, rd_d;

  logic [WORD_W:0]   sr_ext;
  logic [WORD_W-1:0] shifted;
  logic              commit;
  logic [CH_W-1:0]   tgt;
  logic [NUM_CH-1:0] lane_en;
  logic [ACC_W-1:0]  lane_acc [NUM_CH];
  logic [ACC_W-1:0]  lane_sel;

  // Extending by one bit and truncating keeps the shift legal for WORD_W == 1.
  assign sr_ext  = {sr_q, bit_if.IN_data};
  assign shifted = sr_ext[WORD_W-1:0];
  assign commit  = bit_if.IN_valid && bit_if.IN_word && !IN_clear;
  assign tgt     = IN_rr ? ptr_q : IN_ch;

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_lane
      assign lane_en[g] = commit && (tgt == CH_W'(g));
      accum_lane #(.ACC_W(ACC_W), .WORD_W(WORD_W)) u_lane (
        .clk     (clk),
        .rst     (rst),
        .en_i    (lane_en[g]),
        .clear_i (IN_clear),
        .mode_i  (IN_mode),
        .word_i  (shifted),
        .acc_o   (lane_acc[g]),
        .ovf_o   (OUT_ovf[g])
      );
    end
  endgenerate

  always_comb begin
    sr_d   = sr_q;
    ptr_d  = ptr_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    wv_d   = commit;
    if (IN_clear) begin
      sr_d   = '0;
      ptr_d  = '0;
      word_d = '0;
      cnt_d  = '0;
    end else if (bit_if.IN_valid) begin
      sr_d = bit_if.IN_word ? '0 : shifted;
      if (bit_if.IN_word) begin
        word_d = shifted;
        cnt_d  = cnt_q + 16'd1;
        if (IN_rr)
          ptr_d = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
      end
    end
  end

  // Unmatched channel or slice selects fall through to zero.
  always_comb begin
    lane_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (IN_rdCh == CH_W'(c)) lane_sel = lane_acc[c];
    rd_d = '0;
    for (int s = 0; s < NSLICE; s++)
      if (IN_rdSel == SEL_W'(s)) rd_d = lane_sel[s*READ_W +: READ_W];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q   <= '0;
      ptr_q  <= '0;
      word_q <= '0;
      wv_q   <= 1'b0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      sr_q   <= sr_d;
      ptr_q  <= ptr_d;
      word_q <= word_d;
      wv_q   <= wv_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
    end
  end

  assign OUT_rdata     = rd_q;
  assign OUT_word      = word_q;
  assign OUT_wordValid = wv_q;
  assign OUT_wordCnt   = cnt_q;

endmodule
